// File: rtl/bit_serializer.sv
`default_nettype none
// ============================================================================
// Module      : bit_serializer
// Description : Parallel-to-serial feeder for the sequence-detector FSM.
//               Accepts a WIDTH-bit word over a valid/ready handshake and
//               emits it one bit per clock on w, qualified by w_valid, with a
//               done pulse on the last bit. Words may run back-to-back, or be
//               separated by a fixed number of idle (GAP) cycles.
// Ports       : clk        - rising-edge clock
//               reset_n    - synchronous active-low reset
//               data_in    - parallel word, captured on the accept edge
//               data_valid - producer offers a word
//               data_ready - a word can be accepted this cycle
//               w          - serial bit (0 whenever w_valid is 0)
//               w_valid    - w carries a payload bit
//               busy       - FSM is not idle
//               done       - pulse coincident with the last bit of a word
// Revision    : 1.0 - initial release
// ============================================================================
module bit_serializer #(
  parameter int WIDTH     = 8,     // 2..32
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP       = 0      // 0..15
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             w,
  output logic             w_valid,
  output logic             busy,
  output logic             done
);

  localparam int                CW         = $clog2(WIDTH);
  localparam logic [CW-1:0]     c_LAST_BIT = CW'(WIDTH - 1);
  localparam bit                c_HAS_GAP  = (GAP > 0);
  localparam logic [3:0]        c_GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;
  logic [3:0]       gapcnt_q, gapcnt_d;

  logic w_q, w_d;
  logic w_valid_q, w_valid_d;
  logic done_q, done_d;
  logic ready_q, ready_d;
  logic busy_q, busy_d;

  logic             w_transfer;
  logic [WIDTH-1:0] w_shifted;
  logic             w_next_head;

  assign w_transfer = data_valid && ready_q;

  // Bit-order selection: shift direction and which end is the head bit.
  // The head is taken from the next shifter value because w is registered
  // and must show the bit that belongs to the coming cycle.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shifted   = {shreg_q[WIDTH-2:0], 1'b0};
      assign w_next_head = shreg_d[WIDTH-1];
    end else begin : g_lsb_first
      assign w_shifted   = {1'b0, shreg_q[WIDTH-1:1]};
      assign w_next_head = shreg_d[0];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    gapcnt_d = gapcnt_q;
    case (state_q)
      S_IDLE: begin
        if (w_transfer) begin
          state_d  = S_SHIFT;
          shreg_d  = data_in;
          bitcnt_d = '0;
        end
      end
      S_SHIFT: begin
        if (bitcnt_q == c_LAST_BIT) begin
          if (c_HAS_GAP) begin
            state_d  = S_GAP;
            gapcnt_d = 4'd0;
            shreg_d  = '0;
            bitcnt_d = '0;
          end else if (w_transfer) begin
            // Back-to-back reload keeps w_valid continuous.
            shreg_d  = data_in;
            bitcnt_d = '0;
          end else begin
            state_d  = S_IDLE;
            shreg_d  = '0;
            bitcnt_d = '0;
          end
        end else begin
          shreg_d  = w_shifted;
          bitcnt_d = bitcnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gapcnt_q == c_GAP_LAST) begin
          state_d  = S_IDLE;
          gapcnt_d = 4'd0;
        end else begin
          gapcnt_d = gapcnt_q + 4'd1;
        end
      end
      default: begin
        state_d  = S_IDLE;
        shreg_d  = '0;
        bitcnt_d = '0;
        gapcnt_d = 4'd0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registered outputs are derived from the next state so they line up with
  // the state they describe.
  // --------------------------------------------------------------------------
  always_comb begin
    w_valid_d = (state_d == S_SHIFT);
    w_d       = w_valid_d && w_next_head;
    done_d    = w_valid_d && (bitcnt_d == c_LAST_BIT);
    busy_d    = (state_d != S_IDLE);
    ready_d   = (state_d == S_IDLE) || (done_d && !c_HAS_GAP);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      bitcnt_q  <= '0;
      gapcnt_q  <= 4'd0;
      w_q       <= 1'b0;
      w_valid_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bitcnt_q  <= bitcnt_d;
      gapcnt_q  <= gapcnt_d;
      w_q       <= w_d;
      w_valid_q <= w_valid_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
    end
  end

  assign data_ready = ready_q;
  assign w          = w_q;
  assign w_valid    = w_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bit_serializer
// Description : Directed self-checking bench for bit_serializer. Three
//               instances cover MSB-first/GAP=0, MSB-first/GAP=2 and
//               LSB-first/GAP=0. Observed vector is
//               {w, w_valid, done, data_ready, busy}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_serializer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  logic [7:0] data_a = 8'h00, data_b = 8'h00, data_c = 8'h00;
  logic valid_a = 1'b0, valid_b = 1'b0, valid_c = 1'b0;
  logic rdy_a, w_a, wv_a, busy_a, done_a;
  logic rdy_b, w_b, wv_b, busy_b, done_b;
  logic rdy_c, w_c, wv_c, busy_c, done_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(0)) u_a (
    .clk(clk), .reset_n(reset_n), .data_in(data_a), .data_valid(valid_a),
    .data_ready(rdy_a), .w(w_a), .w_valid(wv_a), .busy(busy_a), .done(done_a));

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(2)) u_b (
    .clk(clk), .reset_n(reset_n), .data_in(data_b), .data_valid(valid_b),
    .data_ready(rdy_b), .w(w_b), .w_valid(wv_b), .busy(busy_b), .done(done_b));

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP(0)) u_c (
    .clk(clk), .reset_n(reset_n), .data_in(data_c), .data_valid(valid_c),
    .data_ready(rdy_c), .w(w_c), .w_valid(wv_c), .busy(busy_c), .done(done_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] got4;
    logic [4:0] got;
    reset_n = 1'b0;
    valid_a = 1'b1; valid_b = 1'b1; valid_c = 1'b1;
    data_a = 8'hFF; data_b = 8'hFF; data_c = 8'hFF;
    tick(); tick();
    got4 = {w_a, wv_a, done_a, busy_a};
    checks++;
    if (got4 !== 4'b0000) begin errors++; $display("FAIL reset_a: got %b expected 0000", got4); end
    got4 = {w_b, wv_b, done_b, busy_b};
    checks++;
    if (got4 !== 4'b0000) begin errors++; $display("FAIL reset_b: got %b expected 0000", got4); end
    got4 = {w_c, wv_c, done_c, busy_c};
    checks++;
    if (got4 !== 4'b0000) begin errors++; $display("FAIL reset_c: got %b expected 0000", got4); end
    reset_n = 1'b1;
    valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
    tick();
    got = {w_a, wv_a, done_a, rdy_a, busy_a};
    checks++;
    if (got !== 5'b00010) begin errors++; $display("FAIL post_reset_a: got %b expected 00010", got); end
    got = {w_b, wv_b, done_b, rdy_b, busy_b};
    checks++;
    if (got !== 5'b00010) begin errors++; $display("FAIL post_reset_b: got %b expected 00010", got); end
  endtask

  task automatic test_single_msb();
    logic [7:0] pat;
    logic [4:0] got, exp;
    pat = 8'b1011_0010;  // 8'hB2
    data_a = pat; valid_a = 1'b1;
    tick();
    valid_a = 1'b0; data_a = 8'h00;
    for (int i = 0; i < 8; i++) begin
      got = {w_a, wv_a, done_a, rdy_a, busy_a};
      exp = {pat[7-i], 1'b1, (i == 7), (i == 7), 1'b1};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL b2_bit%0d: got %b expected %b", i, got, exp); end
      tick();
    end
    got = {w_a, wv_a, done_a, rdy_a, busy_a};
    checks++;
    if (got !== 5'b00010) begin errors++; $display("FAIL b2_idle: got %b expected 00010", got); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] got, exp;
    data_a = 8'hFF; valid_a = 1'b1;
    tick();
    data_a = 8'h00;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) valid_a = 1'b0;
      got = {w_a, wv_a, done_a, rdy_a, busy_a};
      exp = {(i < 8), 1'b1, (i == 7 || i == 15), (i == 7 || i == 15), 1'b1};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL b2b_cyc%0d: got %b expected %b", i, got, exp); end
      tick();
    end
    got = {w_a, wv_a, done_a, rdy_a, busy_a};
    checks++;
    if (got !== 5'b00010) begin errors++; $display("FAIL b2b_idle: got %b expected 00010", got); end
  endtask

  task automatic test_gap();
    logic [7:0] p1, p2;
    logic [4:0] got, exp;
    p1 = 8'b1100_0011;   // 8'hC3
    p2 = 8'b0101_1010;   // 8'h5A
    data_b = p1; valid_b = 1'b1;
    tick();
    data_b = p2;
    for (int i = 0; i < 8; i++) begin
      got = {w_b, wv_b, done_b, rdy_b, busy_b};
      exp = {p1[7-i], 1'b1, (i == 7), 1'b0, 1'b1};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL gap_w1_bit%0d: got %b expected %b", i, got, exp); end
      tick();
    end
    for (int g = 0; g < 2; g++) begin
      got = {w_b, wv_b, done_b, rdy_b, busy_b};
      checks++;
      if (got !== 5'b00001) begin errors++; $display("FAIL gap_cyc%0d: got %b expected 00001", g, got); end
      tick();
    end
    got = {w_b, wv_b, done_b, rdy_b, busy_b};
    checks++;
    if (got !== 5'b00010) begin errors++; $display("FAIL gap_idle1: got %b expected 00010", got); end
    tick();
    valid_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      got = {w_b, wv_b, done_b, rdy_b, busy_b};
      exp = {p2[7-i], 1'b1, (i == 7), 1'b0, 1'b1};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL gap_w2_bit%0d: got %b expected %b", i, got, exp); end
      tick();
    end
    tick(); tick();
    got = {w_b, wv_b, done_b, rdy_b, busy_b};
    checks++;
    if (got !== 5'b00010) begin errors++; $display("FAIL gap_idle2: got %b expected 00010", got); end
  endtask

  task automatic test_lsb_first();
    logic [7:0] pat;
    logic [4:0] got, exp;
    pat = 8'h01;
    data_c = pat; valid_c = 1'b1;
    tick();
    valid_c = 1'b0;
    for (int i = 0; i < 8; i++) begin
      got = {w_c, wv_c, done_c, rdy_c, busy_c};
      exp = {pat[i], 1'b1, (i == 7), (i == 7), 1'b1};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL lsb_bit%0d: got %b expected %b", i, got, exp); end
      tick();
    end
  endtask

  task automatic test_reset_midword();
    logic [7:0] pat;
    logic [4:0] got, exp;
    pat = 8'b1010_1010;  // 8'hAA
    data_a = pat; valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      got = {w_a, wv_a, done_a, rdy_a, busy_a};
      exp = {pat[7-i], 1'b1, 1'b0, 1'b0, 1'b1};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL rst_aa_bit%0d: got %b expected %b", i, got, exp); end
      if (i < 3) tick();
    end
    reset_n = 1'b0;
    tick();
    got = {w_a, wv_a, done_a, rdy_a, busy_a};
    checks++;
    if (got !== 5'b00010) begin errors++; $display("FAIL rst_mid: got %b expected 00010", got); end
    reset_n = 1'b1;
    tick();
    got = {w_a, wv_a, done_a, rdy_a, busy_a};
    checks++;
    if (got !== 5'b00010) begin errors++; $display("FAIL rst_after: got %b expected 00010", got); end
    pat = 8'b1111_0000;  // 8'hF0
    data_a = pat; valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      got = {w_a, wv_a, done_a, rdy_a, busy_a};
      exp = {pat[7-i], 1'b1, (i == 7), (i == 7), 1'b1};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL rst_f0_bit%0d: got %b expected %b", i, got, exp); end
      tick();
    end
    got = {w_a, wv_a, done_a, rdy_a, busy_a};
    checks++;
    if (got !== 5'b00010) begin errors++; $display("FAIL rst_f0_idle: got %b expected 00010", got); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_msb();
    test_back_to_back();
    test_gap();
    test_lsb_first();
    test_reset_midword();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
